// File: rtl/staff_note_playback.sv
// Staff playback sequencer: steps through stored staff cells on each sixteenth-note tick
// and turns voice changes into a MIDI note-off/note-on byte stream with valid/ready handshake.
module staff_note_playback #(
    parameter int         NUM_VOICES   = 5,
    parameter int         CELL_W       = 6,
    parameter logic [3:0] MIDI_CHANNEL = 4'h0,
    parameter logic [7:0] VELOCITY     = 8'h40,
    parameter int         RD_LATENCY   = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     play_in,
    input  logic                     tick_in,
    input  logic [CELL_W-1:0]        start_cell_in,
    input  logic [CELL_W-1:0]        end_cell_in,
    output logic [CELL_W-1:0]        cell_addr_out,
    input  logic [12*NUM_VOICES-1:0] cell_data_in,
    output logic [7:0]               byte_out,
    output logic                     byte_valid_out,
    input  logic                     byte_ready_in,
    output logic [CELL_W-1:0]        current_cell_out,
    output logic                     busy_out,
    output logic                     tick_missed_out
);

    localparam int         SLOT_W   = $clog2(NUM_VOICES + 1);
    localparam int         CNT_W    = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
    localparam logic [7:0] EMPTY    = 8'hFF;
    localparam logic [7:0] NOTE_OFF = {4'h8, MIDI_CHANNEL};
    localparam logic [7:0] NOTE_ON  = {4'h9, MIDI_CHANNEL};

    typedef enum logic [2:0] {
        STOPPED, IDLE, WAIT, LATCH, COMPARE, SEND, ADVANCE, FLUSH
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [SLOT_W-1:0]   slot;
    logic [1:0]          byte_idx;
    logic [7:0]          msg_b1;
    logic [7:0]          msg_b2;
    logic                pend_on;
    logic [7:0]          pend_note;
    logic                flushing;
    logic [7:0]          note_q [NUM_VOICES];
    logic [7:0]          active [NUM_VOICES];
    logic [7:0]          cur_new;
    logic [7:0]          cur_act;
    logic                last_slot;

    // The rhythm nibbles share the cell word but have no meaning for playback.
    logic [4*NUM_VOICES-1:0] rhythm_bits;
    logic                    unused_rhythm;

    function automatic logic note_valid(input logic [7:0] n);
        return !n[7];
    endfunction

    always_comb begin
        rhythm_bits = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            rhythm_bits[4*i +: 4] = cell_data_in[12*i+8 +: 4];
        end
    end
    assign unused_rhythm = ^rhythm_bits;

    assign cur_new   = note_q[slot];
    assign cur_act   = active[slot];
    assign last_slot = (slot == SLOT_W'(NUM_VOICES - 1));
    assign busy_out  = !(state == IDLE || state == STOPPED);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= STOPPED;
            cell_addr_out    <= '0;
            current_cell_out <= '0;
            byte_out         <= '0;
            byte_valid_out   <= 1'b0;
            tick_missed_out  <= 1'b0;
            cnt              <= '0;
            slot             <= '0;
            byte_idx         <= '0;
            pend_on          <= 1'b0;
            flushing         <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) active[i] <= EMPTY;
        end else begin
            tick_missed_out <= tick_in && busy_out;
            case (state)
                STOPPED: begin
                    cell_addr_out    <= start_cell_in;
                    current_cell_out <= start_cell_in;
                    flushing         <= 1'b0;
                    if (play_in) state <= IDLE;
                end
                IDLE: begin
                    if (!play_in) begin
                        slot     <= '0;
                        flushing <= 1'b1;
                        state    <= FLUSH;
                    end else if (tick_in) begin
                        cnt   <= CNT_W'(RD_LATENCY);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt <= CNT_W'(1)) state <= LATCH;
                    else                  cnt   <= cnt - CNT_W'(1);
                end
                LATCH: begin
                    for (int i = 0; i < NUM_VOICES; i++) note_q[i] <= cell_data_in[12*i +: 8];
                    slot  <= '0;
                    state <= COMPARE;
                end
                COMPARE: begin
                    slot <= slot + SLOT_W'(1);
                    if (cur_new != cur_act) begin
                        active[slot] <= cur_new;
                        if (note_valid(cur_act)) begin
                            // Old note is released first; the new one rides along as a pending note-on.
                            byte_out       <= NOTE_OFF;
                            msg_b1         <= cur_act;
                            msg_b2         <= 8'h00;
                            byte_valid_out <= 1'b1;
                            byte_idx       <= '0;
                            pend_on        <= note_valid(cur_new);
                            pend_note      <= cur_new;
                            state          <= SEND;
                        end else if (note_valid(cur_new)) begin
                            byte_out       <= NOTE_ON;
                            msg_b1         <= cur_new;
                            msg_b2         <= VELOCITY;
                            byte_valid_out <= 1'b1;
                            byte_idx       <= '0;
                            pend_on        <= 1'b0;
                            state          <= SEND;
                        end else if (last_slot) begin
                            state <= ADVANCE;
                        end
                    end else if (last_slot) begin
                        state <= ADVANCE;
                    end
                end
                SEND: begin
                    if (byte_ready_in) begin
                        case (byte_idx)
                            2'd0: begin
                                byte_out <= msg_b1;
                                byte_idx <= 2'd1;
                            end
                            2'd1: begin
                                byte_out <= msg_b2;
                                byte_idx <= 2'd2;
                            end
                            default: begin
                                byte_idx <= '0;
                                if (pend_on) begin
                                    byte_out <= NOTE_ON;
                                    msg_b1   <= pend_note;
                                    msg_b2   <= VELOCITY;
                                    pend_on  <= 1'b0;
                                end else begin
                                    byte_valid_out <= 1'b0;
                                    if (flushing)                             state <= FLUSH;
                                    else if (slot == SLOT_W'(NUM_VOICES))     state <= ADVANCE;
                                    else                                      state <= COMPARE;
                                end
                            end
                        endcase
                    end
                end
                ADVANCE: begin
                    current_cell_out <= cell_addr_out;
                    cell_addr_out    <= (cell_addr_out == end_cell_in) ? start_cell_in
                                                                        : cell_addr_out + CELL_W'(1);
                    state            <= IDLE;
                end
                FLUSH: begin
                    if (slot == SLOT_W'(NUM_VOICES)) begin
                        state <= STOPPED;
                    end else begin
                        slot <= slot + SLOT_W'(1);
                        if (note_valid(cur_act)) begin
                            active[slot]   <= EMPTY;
                            byte_out       <= NOTE_OFF;
                            msg_b1         <= cur_act;
                            msg_b2         <= 8'h00;
                            byte_valid_out <= 1'b1;
                            byte_idx       <= '0;
                            pend_on        <= 1'b0;
                            state          <= SEND;
                        end
                    end
                end
                default: state <= STOPPED;
            endcase
        end
    end

endmodule

// File: tb/tb_staff_note_playback.sv
// Bench for staff_note_playback: a staff-level reference model predicts the MIDI byte stream
// into a queue, and an independent monitor checks every accepted byte against it.
module tb_staff_note_playback;

    localparam int         NV  = 5;
    localparam int         CW  = 6;
    localparam int         RL  = 2;
    localparam logic [3:0] CH  = 4'h0;
    localparam logic [7:0] VEL = 8'h40;

    logic              clk = 1'b0;
    logic              rst, play, tick, bready, bvalid, busy, missed;
    logic [CW-1:0]     start_c, end_c, addr, cur;
    logic [12*NV-1:0]  cdata;
    logic [7:0]        bout;

    always #5 clk = ~clk;

    staff_note_playback #(
        .NUM_VOICES(NV), .CELL_W(CW), .MIDI_CHANNEL(CH), .VELOCITY(VEL), .RD_LATENCY(RL)
    ) dut (
        .clk_in(clk), .rst_in(rst), .play_in(play), .tick_in(tick),
        .start_cell_in(start_c), .end_cell_in(end_c), .cell_addr_out(addr),
        .cell_data_in(cdata), .byte_out(bout), .byte_valid_out(bvalid),
        .byte_ready_in(bready), .current_cell_out(cur), .busy_out(busy),
        .tick_missed_out(missed)
    );

    // Staff memory with a two-cycle registered read path
    logic [12*NV-1:0] mem [64];
    logic [12*NV-1:0] rd_p0, rd_p1;
    always @(posedge clk) begin
        rd_p0 <= mem[addr];
        rd_p1 <= rd_p0;
    end
    assign cdata = rd_p1;

    logic [7:0]    act_m [NV];
    logic [CW-1:0] next_m;
    logic [7:0]    exp_q [$];
    int            errors = 0;
    int            checks = 0;
    int            missed_cnt = 0;
    int            ready_mode = 0;
    int            lat;

    function automatic void check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endfunction

    // Reference model: one staff cell played, voice by voice
    task automatic model_play(output logic [CW-1:0] played);
        logic [7:0] n;
        played = next_m;
        for (int i = 0; i < NV; i++) begin
            n = mem[played][12*i +: 8];
            if (n != act_m[i]) begin
                if (!act_m[i][7]) begin
                    exp_q.push_back(8'h80 | {4'h0, CH});
                    exp_q.push_back(act_m[i]);
                    exp_q.push_back(8'h00);
                end
                if (!n[7]) begin
                    exp_q.push_back(8'h90 | {4'h0, CH});
                    exp_q.push_back(n);
                    exp_q.push_back(VEL);
                end
                act_m[i] = n;
            end
        end
        next_m = (played == end_c) ? start_c : CW'(played + 1);
    endtask

    task automatic model_flush();
        for (int i = 0; i < NV; i++) begin
            if (!act_m[i][7]) begin
                exp_q.push_back(8'h80 | {4'h0, CH});
                exp_q.push_back(act_m[i]);
                exp_q.push_back(8'h00);
            end
            act_m[i] = 8'hFF;
        end
    endtask

    task automatic set_slot(input logic [CW-1:0] c, input int i, input logic [7:0] n);
        mem[c][12*i +: 8]   = n;
        mem[c][12*i+8 +: 4] = 4'($urandom);
    endtask

    function automatic logic [7:0] pick(input int i);
        int r = $urandom_range(0, 7);
        if (r <= 2) return 8'hFF;
        if (r == 3) return 8'h80 | 8'($urandom_range(0, 127));
        if (r == 4) return act_m[i];
        return 8'($urandom_range(0, 127));
    endfunction

    // Monitor: pops on every handshake, and holds an un-accepted byte to the same value
    initial begin
        logic [7:0] held_b;
        logic       held;
        held = 1'b0;
        held_b = 8'h00;
        forever begin
            @(negedge clk);
            if (missed) missed_cnt++;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("valid_held", int'(bvalid), 1);
                    if (bvalid) check("byte_stable", int'(bout), int'(held_b));
                end
                if (bvalid && bready) begin
                    if (exp_q.size() == 0) check("unexpected_byte", int'(bout), -1);
                    else                   check("byte", int'(bout), int'(exp_q.pop_front()));
                end
                held   = bvalid && !bready;
                held_b = bout;
            end
        end
    end

    initial begin
        int phase = 0;
        bready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bready = 1'b1;
                1: bready = 1'($urandom_range(0, 1));
                2: begin
                    phase  = (phase + 1) % 3;
                    bready = (phase == 0);
                end
                default: ;
            endcase
        end
    end

    task automatic do_tick(input bit dbl, output int latency);
        logic [CW-1:0] played;
        int k;
        check("cell_addr", int'(addr), int'(next_m));
        model_play(played);
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        latency = -1;
        k = 0;
        while (k < 600) begin
            @(negedge clk);
            k++;
            if (bvalid && latency < 0) latency = k - 1;
            if (dbl && k == 2) tick = 1'b1;
            if (dbl && k == 3) tick = 1'b0;
            if (!busy && k >= 3) break;
        end
        check("busy_after_cell", int'(busy), 0);
        check("current_cell", int'(cur), int'(played));
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic stop_play();
        int k = 0;
        play = 1'b0;
        model_flush();
        @(posedge clk);
        while (k < 600) begin
            @(negedge clk);
            k++;
            if (!busy) break;
        end
        check("busy_after_flush", int'(busy), 0);
        check("flush_drained", exp_q.size(), 0);
    endtask

    task automatic start_play(input logic [CW-1:0] s, input logic [CW-1:0] e);
        start_c = s;
        end_c   = e;
        play    = 1'b1;
        next_m  = s;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0;
        rst = 1'b1; play = 1'b0; tick = 1'b0; start_c = '0; end_c = 6'd63;
        for (int c = 0; c < 64; c++) mem[c] = '1;
        for (int i = 0; i < NV; i++) act_m[i] = 8'hFF;
        next_m = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(bvalid), 0);
        check("rst_byte", int'(bout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_missed", int'(missed), 0);
        check("rst_cur", int'(cur), 0);
        check("rst_addr", int'(addr), 0);
        rst = 1'b0;

        // First note, then sustain, then a pitch change
        set_slot(0, 0, 8'h3C);
        start_play(6'd0, 6'd63);
        do_tick(1'b0, lat);
        check("first_byte_latency_ok", int'(lat >= 0 && lat <= RL + 3), 1);
        set_slot(1, 0, 8'h3C);
        do_tick(1'b0, lat);
        check("sustain_no_bytes", lat, -1);
        set_slot(2, 0, 8'h3E);
        do_tick(1'b0, lat);

        // Loop bounds, including wrap through the top of the address space
        stop_play();
        for (int i = 0; i < NV; i++) begin
            set_slot(2, i, pick(i));
            set_slot(3, i, pick(i));
        end
        start_play(6'd2, 6'd3);
        repeat (4) do_tick(1'b0, lat);
        stop_play();
        start_play(6'd62, 6'd1);
        repeat (4) do_tick(1'b0, lat);

        // Throttled downstream during a six-byte cell
        stop_play();
        mem[10] = '1;
        mem[11] = '1;
        set_slot(10, 0, 8'h3C);
        set_slot(11, 0, 8'h3E);
        start_play(6'd10, 6'd11);
        do_tick(1'b0, lat);
        ready_mode = 2;
        do_tick(1'b0, lat);
        ready_mode = 0;

        // Tick arriving while a cell is still in flight
        m0 = missed_cnt;
        do_tick(1'b1, lat);
        check("missed_pulses", missed_cnt - m0, 1);
        stop_play();
        m0 = missed_cnt;
        tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        repeat (3) @(negedge clk);
        check("stopped_tick_ignored", missed_cnt - m0, 0);
        check("stopped_tick_busy", int'(busy), 0);

        // Flush of two voices, then reset in the middle of a flush message
        mem[20] = '1;
        set_slot(20, 0, 8'h3C);
        set_slot(20, 3, 8'h43);
        start_play(6'd20, 6'd20);
        do_tick(1'b0, lat);
        stop_play();
        start_play(6'd20, 6'd20);
        do_tick(1'b0, lat);
        ready_mode = 3;
        @(posedge clk); #1 bready = 1'b0;
        play = 1'b0;
        model_flush();
        for (int k = 0; k < 50 && !bvalid; k++) @(negedge clk);
        check("flush_started", int'(bvalid), 1);
        @(posedge clk); #1 bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_valid", int'(bvalid), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_byte", int'(bout), 0);
        exp_q.delete();
        for (int i = 0; i < NV; i++) act_m[i] = 8'hFF;
        @(posedge clk); #1 rst = 1'b0;
        ready_mode = 0;
        start_play(6'd20, 6'd20);
        do_tick(1'b0, lat);

        // Randomised cells, loop bounds and downstream readiness
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                stop_play();
                start_play(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
            end
            ready_mode = $urandom_range(0, 1);
            for (int i = 0; i < NV; i++) set_slot(next_m, i, pick(i));
            do_tick(1'b0, lat);
        end
        ready_mode = 0;
        stop_play();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
